program_loader: RTL and testbench

- Initiator side of the instruction-memory write port (wr_instr_en / wr_instr_addr / wr_instr) on computer_integration.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes the words to consecutive instruction addresses from 0, holding the computer in reset and suspended while loading, then releases it to run.

---
 rtl/program_loader.sv | 200 ++++++++++++++++++++
 tb/tb_program_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
`default_nettype none
// program_loader: assembles a big-endian byte stream into instruction words and writes them from address 0,
// holding the computer in reset until the load completes. Define LOADER_CHECKSUM_EN for a trailing checksum byte.
module program_loader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_instr_en,
  output logic [ADDR_W-1:0] wr_instr_addr,
  output logic [DATA_W-1:0] wr_instr,
  output logic              comp_rst,
  output logic              comp_en,
  output logic              busy,
`ifdef LOADER_CHECKSUM_EN
  output logic              error,
`endif
  output logic              done
);

  localparam int BYTES = DATA_W / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES - 1);
  localparam logic [BC_W-1:0]   BC_ONE    = 1;
  localparam logic [ADDR_W:0]   CAP       = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   REM_ONE   = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WRITE   = 3'd2,
    S_RELEASE = 3'd3,
    S_RUN     = 3'd4
`ifdef LOADER_CHECKSUM_EN
    ,
    S_CHECK   = 3'd5,
    S_ERROR   = 3'd6
`endif
  } state_t;

  state_t            state_q;
  logic [ADDR_W:0]   remaining_q;
  logic [BC_W-1:0]   byte_cnt_q;
  logic [DATA_W-1:0] asm_q;
  logic              byte_ready_q;
  logic              wr_instr_en_q;
  logic [ADDR_W-1:0] wr_instr_addr_q;
  logic [DATA_W-1:0] wr_instr_q;
  logic              comp_rst_q;
  logic              comp_en_q;
  logic              busy_q;
  logic              done_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
  logic              error_q;
`endif

  logic [ADDR_W:0]   load_cnt_d;
  logic [DATA_W-1:0] asm_d;
  logic              can_start_d;

  assign load_cnt_d = (word_count > CAP) ? CAP : word_count;
  // Earlier bytes shift toward the MSB, so the first byte ends up in the top lane.
  assign asm_d      = (asm_q << 8) | DATA_W'(byte_data);
  assign can_start_d = (state_q == S_IDLE) || (state_q == S_RUN)
`ifdef LOADER_CHECKSUM_EN
                       || (state_q == S_ERROR)
`endif
                       ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      remaining_q     <= '0;
      byte_cnt_q      <= '0;
      asm_q           <= '0;
      byte_ready_q    <= 1'b0;
      wr_instr_en_q   <= 1'b0;
      wr_instr_addr_q <= '0;
      wr_instr_q      <= '0;
      comp_rst_q      <= 1'b0;
      comp_en_q       <= 1'b1;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q           <= '0;
      error_q         <= 1'b0;
`endif
    end else if (start && can_start_d) begin
      comp_rst_q  <= 1'b0;
      comp_en_q   <= 1'b1;
      done_q      <= 1'b0;
      busy_q      <= 1'b1;
      byte_cnt_q  <= '0;
      remaining_q <= load_cnt_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
      error_q     <= 1'b0;
`endif
      if (load_cnt_d != '0) begin
        state_q         <= S_LOAD;
        wr_instr_addr_q <= '0;
        byte_ready_q    <= 1'b1;
      end else begin
`ifdef LOADER_CHECKSUM_EN
        state_q      <= S_CHECK;
        byte_ready_q <= 1'b1;
`else
        state_q      <= S_RELEASE;
        byte_ready_q <= 1'b0;
`endif
      end
    end else begin
      case (state_q)
        S_LOAD: begin
          if (byte_valid && byte_ready_q) begin
            asm_q <= asm_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q <= sum_q + byte_data;
`endif
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_q    <= '0;
              byte_ready_q  <= 1'b0;
              wr_instr_en_q <= 1'b1;
              wr_instr_q    <= asm_d;
              state_q       <= S_WRITE;
            end else begin
              byte_cnt_q <= byte_cnt_q + BC_ONE;
            end
          end
        end
        S_WRITE: begin
          wr_instr_en_q <= 1'b0;
          remaining_q   <= remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) begin
`ifdef LOADER_CHECKSUM_EN
            state_q      <= S_CHECK;
            byte_ready_q <= 1'b1;
`else
            state_q      <= S_RELEASE;
`endif
          end else begin
            wr_instr_addr_q <= wr_instr_addr_q + ADDR_ONE;
            byte_ready_q    <= 1'b1;
            state_q         <= S_LOAD;
          end
        end
        // One settling cycle with the computer still held, so the last write lands first.
        S_RELEASE: begin
          state_q    <= S_RUN;
          comp_rst_q <= 1'b1;
          comp_en_q  <= 1'b0;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (byte_valid && byte_ready_q) begin
            byte_ready_q <= 1'b0;
            if (byte_data == sum_q) begin
              state_q <= S_RELEASE;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        S_ERROR: begin
        end
`endif
        S_IDLE, S_RUN: begin
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign byte_ready    = byte_ready_q;
  assign wr_instr_en   = wr_instr_en_q;
  assign wr_instr_addr = wr_instr_addr_q;
  assign wr_instr      = wr_instr_q;
  assign comp_rst      = comp_rst_q;
  assign comp_en       = comp_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign error         = error_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// tb_program_loader: directed and randomized loads of program_loader checked against a byte-stream model.
module tb_program_loader;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int BYTES  = DATA_W / 8;
  localparam int CAP    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_instr_en;
  logic [ADDR_W-1:0] wr_instr_addr;
  logic [DATA_W-1:0] wr_instr;
  logic              comp_rst;
  logic              comp_en;
  logic              busy;
  logic              done;
`ifdef LOADER_CHECKSUM_EN
  logic              error;
`endif

  program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .word_count    (word_count),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (byte_ready),
    .wr_instr_en   (wr_instr_en),
    .wr_instr_addr (wr_instr_addr),
    .wr_instr      (wr_instr),
    .comp_rst      (comp_rst),
    .comp_en       (comp_en),
    .busy          (busy),
`ifdef LOADER_CHECKSUM_EN
    .error         (error),
`endif
    .done          (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]        stream   [$];
  logic [ADDR_W-1:0] got_addr [$];
  logic [DATA_W-1:0] got_data [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every strobe seen by the memory side is logged for comparison with the model.
  always @(negedge clk) begin
    if (rst === 1'b1 && wr_instr_en === 1'b1) begin
      got_addr.push_back(wr_instr_addr);
      got_data.push_back(wr_instr);
      chk("ready_low_in_write", 64'(byte_ready), 64'd0);
    end
  end

  task automatic fill_seq(input int n);
    stream.delete();
    for (int i = 0; i < n; i++) stream.push_back(8'(i));
  endtask

  task automatic fill_rand(input int n);
    stream.delete();
    for (int i = 0; i < n; i++) stream.push_back(8'($urandom));
  endtask

  task automatic do_start(input int wc);
    got_addr.delete();
    got_data.delete();
    word_count = wc[ADDR_W:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random valid
  task automatic feed(input int base, input int n, input int mode, input bit lat);
    int idx = 0;
    int guard = 0;
    bit pend = 1'b0;
    bit tog = 1'b1;
    bit v;
    forever begin
      if (pend) begin
        if (lat && (idx % BYTES == BYTES - 1))
          chk("strobe_latency", 64'(wr_instr_en), 64'd1);
        idx++;
      end
      if (idx == n) begin
        byte_valid = 1'b0;
        break;
      end
      if (guard > 8 * n + 64) begin
        chk("feed_timeout", 64'(idx), 64'(n));
        byte_valid = 1'b0;
        break;
      end
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = ~tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      byte_valid = v;
      byte_data  = v ? stream[base + idx] : 8'($urandom);
      pend = v && (byte_ready === 1'b1);
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic send_ck(input int nbytes, input int mode);
    logic [7:0] s = 8'd0;
    for (int i = 0; i < nbytes; i++) s = s + stream[i];
    if (stream.size() > nbytes) stream[nbytes] = s;
    else stream.push_back(s);
    feed(nbytes, 1, mode, 1'b0);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_reached", 64'(done), 64'd1);
  endtask

  task automatic check_writes(input int nw);
    logic [DATA_W-1:0] exp;
    #1;
    chk("write_count", 64'(got_addr.size()), 64'(nw));
    for (int k = 0; k < nw && k < got_addr.size(); k++) begin
      exp = '0;
      for (int b = 0; b < BYTES; b++) exp = (exp << 8) | DATA_W'(stream[k * BYTES + b]);
      chk("write_addr", 64'(got_addr[k]), 64'(k));
      chk("write_data", 64'(got_data[k]), 64'(exp));
    end
  endtask

  task automatic run_load(input int wc, input int mode);
    int nw = (wc > CAP) ? CAP : wc;
    do_start(wc);
    feed(0, nw * BYTES, mode, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_ck(nw * BYTES, mode);
`endif
    wait_done(20);
    check_writes(nw);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctrl"}, 64'({wr_instr_en, comp_rst, comp_en, byte_ready, busy, done}), 64'(6'b001000));
    chk({tag, "_addr"}, 64'(wr_instr_addr), 64'd0);
    chk({tag, "_data"}, 64'(wr_instr), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    word_count = '0;
    byte_valid = 1'b0;
    byte_data = 8'd0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
`ifdef LOADER_CHECKSUM_EN
    chk("reset_error", 64'(error), 64'd0);
`endif
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_hold", 64'({comp_rst, comp_en, byte_ready, wr_instr_en, busy, done}), 64'(6'b010000));
    end

    // Single word, back-to-back bytes.
    stream.delete();
    stream.push_back(8'h20); stream.push_back(8'h01);
    stream.push_back(8'h00); stream.push_back(8'h05);
    do_start(1);
    feed(0, 4, 0, 1'b1);
    chk("w1_data", 64'(wr_instr), 64'h20010005);
    chk("w1_addr", 64'(wr_instr_addr), 64'd0);
`ifndef LOADER_CHECKSUM_EN
    @(negedge clk);
    chk("w1_release", 64'({comp_rst, comp_en, done, wr_instr_en}), 64'(4'b0100));
    @(negedge clk);
    chk("w1_run", 64'({comp_rst, comp_en, done, busy}), 64'(4'b1010));
`else
    send_ck(4, 0);
    wait_done(20);
`endif
    check_writes(1);

    // Three words with valid toggling.
    fill_seq(12);
    run_load(3, 1);

    // Empty load.
    stream.delete();
    do_start(0);
`ifndef LOADER_CHECKSUM_EN
    chk("w0_release", 64'({comp_rst, comp_en, done}), 64'(3'b010));
    @(negedge clk);
    chk("w0_run", 64'({comp_rst, comp_en, done}), 64'(3'b101));
`else
    send_ck(0, 0);
    wait_done(20);
`endif
    check_writes(0);

    // Full-capacity load, then an oversized count that must clamp.
    fill_rand(CAP * BYTES);
    run_load(CAP, 2);
    repeat (10) @(negedge clk);
    check_writes(CAP);
    fill_rand(2 * CAP * BYTES);
    run_load(255, 0);

    // Restart from RUN, then reset in the middle of the second word.
    fill_rand(2 * BYTES);
    do_start(2);
    chk("restart_hold", 64'({comp_rst, comp_en, done, busy, byte_ready}), 64'(5'b01011));
    feed(0, BYTES + 2, 0, 1'b1);
    rst = 1'b0;
    #1;
    chk_reset("midload_reset");
    chk("midload_writes", 64'(got_addr.size()), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_reset_quiet", 64'({got_addr.size() == 1, wr_instr_en, comp_rst}), 64'(3'b100));
    fill_rand(BYTES);
    run_load(1, 2);

    // Randomized loads.
    for (int it = 0; it < 6; it++) begin
      int wc = $urandom_range(1, 6);
      fill_rand(wc * BYTES);
      run_load(wc, $urandom_range(0, 2));
    end

`ifdef LOADER_CHECKSUM_EN
    stream.delete();
    stream.push_back(8'h01); stream.push_back(8'h02);
    stream.push_back(8'h03); stream.push_back(8'h04);
    stream.push_back(8'h0A);
    do_start(1);
    feed(0, 4, 0, 1'b1);
    feed(4, 1, 0, 1'b0);
    wait_done(10);
    chk("ck_good_error", 64'(error), 64'd0);
    check_writes(1);
    stream[4] = 8'h0B;
    do_start(1);
    feed(0, 4, 0, 1'b1);
    feed(4, 1, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("ck_bad", 64'({error, comp_rst, comp_en, done, busy}), 64'(5'b10100));
    stream.delete();
    stream.push_back(8'h00);
    do_start(0);
    feed(0, 1, 0, 1'b0);
    wait_done(10);
    chk("ck_zero_error", 64'(error), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
